// File: rtl/cbus_wrr_arbiter_if.sv
// Cached-bus transaction types plus the interface bundling the requester-side
// and memory-side request/response buses of the weighted round-robin arbiter.
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

interface cbus_wrr_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import cbus_pkg::*;

  cbus_req_t  [NUM_REQ-1:0] ireqs;
  cbus_resp_t [NUM_REQ-1:0] iresps;
  cbus_req_t                oreq;
  cbus_resp_t               oresp;

  // master: the requesters plus memory that surround the arbiter
  modport master (output ireqs, oresp, input iresps, oreq);
  modport slave  (input ireqs, oresp, output iresps, oreq);
endinterface

// File: rtl/cbus_wrr_arbiter.sv
// Weighted round-robin, transaction-locked arbiter sharing one cbus master port.
// One idle arbitration cycle per grant; grant held until the last beat is accepted.
module cbus_wrr_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int WEIGHT_W = 4,
  parameter int TIMEOUT  = 1024,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  cbus_wrr_arbiter_if.slave            bus,
  input  logic [NUM_REQ*WEIGHT_W-1:0]  cfg_weight,
  output logic [IDX_W-1:0]             grant_idx,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(TIMEOUT - 1);

  logic [0:0]                         state_q, state_d;
  logic [IDX_W-1:0]                   sel_q, sel_d;
  logic [IDX_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0][WEIGHT_W-1:0]   credit_q, credit_d;
  logic                               fresh_q, fresh_d;
  logic [CNT_W-1:0]                   stall_cnt_q, stall_cnt_d;
  logic                               timeout_q, timeout_d;

  logic [NUM_REQ-1:0][WEIGHT_W-1:0]   eff_w;
  logic [NUM_REQ-1:0][WEIGHT_W-1:0]   credit_cur;
  logic [NUM_REQ-1:0]                 req_vld;
  logic [NUM_REQ-1:0]                 cand;

  // First set bit at or after ptr, cyclic; lowest offset wins.
  function automatic logic [IDX_W-1:0] pick(input logic [NUM_REQ-1:0] m,
                                            input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] res;
    int idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (m[idx]) res = IDX_W'(idx);
    end
    return res;
  endfunction

  // fresh_q stands in for "credits equal the configured weights" after reset,
  // so reset itself never has to load a non-constant value into credit_q.
  always_comb begin
    eff_w      = '0;
    credit_cur = '0;
    req_vld    = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eff_w[i]      = (cfg_weight[i*WEIGHT_W +: WEIGHT_W] == '0) ?
                      WEIGHT_W'(1) : cfg_weight[i*WEIGHT_W +: WEIGHT_W];
      credit_cur[i] = fresh_q ? eff_w[i] : credit_q[i];
      req_vld[i]    = bus.ireqs[i].valid;
      cand[i]       = req_vld[i] && (credit_cur[i] != '0);
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_ptr_d    = rr_ptr_q;
    credit_d    = credit_q;
    fresh_d     = fresh_q;
    stall_cnt_d = stall_cnt_q;
    timeout_d   = timeout_q;
    bus.oreq    = '0;
    bus.iresps  = '0;

    case (state_q)
      IDLE: begin
        stall_cnt_d = '0;
        if (|cand) begin
          sel_d    = pick(cand, rr_ptr_q);
          credit_d = credit_cur;
          fresh_d  = 1'b0;
          state_d  = BUSY;
        end else if (|req_vld) begin
          // every waiting requester is out of credit: open a new window
          sel_d    = pick(req_vld, rr_ptr_q);
          credit_d = eff_w;
          fresh_d  = 1'b0;
          state_d  = BUSY;
        end
      end

      BUSY: begin
        bus.oreq          = bus.ireqs[sel_q];
        bus.iresps[sel_q] = bus.oresp;
        if (bus.oresp.ready) begin
          stall_cnt_d = '0;
          if (bus.oresp.last) begin
            if (credit_q[sel_q] != '0)
              credit_d[sel_q] = credit_q[sel_q] - WEIGHT_W'(1);
            rr_ptr_d = (sel_q == IDX_W'(NUM_REQ - 1)) ? '0 : sel_q + IDX_W'(1);
            state_d  = IDLE;
          end
        end else begin
          if (stall_cnt_q != STALL_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
          if (stall_cnt_d == STALL_MAX) timeout_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      credit_q    <= '0;
      fresh_q     <= 1'b1;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      credit_q    <= credit_d;
      fresh_q     <= fresh_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant_idx   = sel_q;
  assign busy        = (state_q == BUSY);
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_cbus_wrr_arbiter.sv
// Directed bench for cbus_wrr_arbiter: reset, single beat, burst lock,
// weighted share, zero weights, watchdog and asynchronous reset mid-burst.
module tb_cbus_wrr_arbiter;
  import cbus_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] cfg_weight;
  logic [0:0] grant_idx;
  logic       busy;
  logic       timeout_err;

  int tests = 0;
  int fails = 0;

  cbus_wrr_arbiter_if #(.NUM_REQ(2)) bus ();

  cbus_wrr_arbiter #(
    .NUM_REQ (2),
    .WEIGHT_W(4),
    .TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .cfg_weight (cfg_weight),
    .grant_idx  (grant_idx),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] len,
                         input logic [31:0] addr);
    bus.ireqs[i].valid    = v;
    bus.ireqs[i].is_write = 1'b0;
    bus.ireqs[i].size     = 3'd2;
    bus.ireqs[i].addr     = addr;
    bus.ireqs[i].strobe   = 4'hf;
    bus.ireqs[i].data     = 32'h0;
    bus.ireqs[i].len      = len;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_wait_busy"}, 128'(busy), 128'(1));
  endtask

  // Wait for the grant, check owner, then feed beats with last on the final one.
  task automatic serve(input int exp_idx, input int beats, input string tag);
    wait_busy(tag);
    chk({tag, "_grant"}, 128'(grant_idx), 128'(exp_idx));
    for (int b = 0; b < beats; b++) begin
      bus.oresp.ready = 1'b1;
      bus.oresp.last  = (b == beats - 1);
      bus.oresp.data  = 32'hd000_0000 + 32'(b);
      #1;
      chk({tag, "_iresp_ready"}, 128'(bus.iresps[exp_idx].ready), 128'(1));
      tick();
    end
    bus.oresp = '0;
    #1;
    chk({tag, "_idle_after"}, 128'(busy), 128'(0));
  endtask

  int exp_wrr  [9] = '{0, 1, 0, 0, 1, 0, 0, 0, 1};
  int exp_zero [4] = '{0, 1, 0, 1};

  initial begin
    reset      = 1'b1;
    bus.ireqs  = '0;
    bus.oresp  = '0;
    cfg_weight = {4'd1, 4'd1};
    #2;
    chk("rst_oreq",    128'(bus.oreq),   128'(0));
    chk("rst_iresps",  128'(bus.iresps), 128'(0));
    chk("rst_busy",    128'(busy),       128'(0));
    chk("rst_timeout", 128'(timeout_err),128'(0));
    chk("rst_grant",   128'(grant_idx),  128'(0));
    #10;
    reset = 1'b0;
    tick();

    // Single beat read from requester 0
    set_req(0, 1'b1, 8'd0, 32'h0000_1000);
    #1;
    chk("sb_arb_busy",  128'(busy),           128'(0));
    chk("sb_arb_oreq",  128'(bus.oreq.valid), 128'(0));
    tick();
    chk("sb_busy",      128'(busy),           128'(1));
    chk("sb_oreq_vld",  128'(bus.oreq.valid), 128'(1));
    chk("sb_oreq_addr", 128'(bus.oreq.addr),  128'(32'h0000_1000));
    chk("sb_grant",     128'(grant_idx),      128'(0));
    chk("sb_no_ready",  128'(bus.iresps[0].ready), 128'(0));
    tick();
    tick();
    bus.oresp.ready = 1'b1;
    bus.oresp.last  = 1'b1;
    bus.oresp.data  = 32'hcafe_f00d;
    #1;
    chk("sb_ir0_ready", 128'(bus.iresps[0].ready), 128'(1));
    chk("sb_ir0_last",  128'(bus.iresps[0].last),  128'(1));
    chk("sb_ir0_data",  128'(bus.iresps[0].data),  128'(32'hcafe_f00d));
    chk("sb_ir1_zero",  128'(bus.iresps[1]),       128'(0));
    tick();
    set_req(0, 1'b0, 8'd0, 32'h0);
    bus.oresp = '0;
    #1;
    chk("sb_done_busy", 128'(busy), 128'(0));

    // Burst lock: requester 0 owns four beats while requester 1 waits
    tick();
    pulse_reset();
    set_req(0, 1'b1, 8'd3, 32'h0000_b000);
    set_req(1, 1'b1, 8'd0, 32'h0000_c000);
    wait_busy("bl0");
    chk("bl_grant0", 128'(grant_idx), 128'(0));
    for (int b = 0; b < 4; b++) begin
      bus.oresp.ready = 1'b1;
      bus.oresp.last  = (b == 3);
      #1;
      chk($sformatf("bl_owner_addr_%0d", b), 128'(bus.oreq.addr), 128'(32'h0000_b000));
      chk($sformatf("bl_ir1_zero_%0d", b),   128'(bus.iresps[1]), 128'(0));
      tick();
    end
    bus.oresp = '0;
    set_req(0, 1'b0, 8'd0, 32'h0);
    #1;
    chk("bl_gap_busy", 128'(busy),           128'(0));
    chk("bl_gap_oreq", 128'(bus.oreq.valid), 128'(0));
    tick();
    chk("bl_grant1_busy", 128'(busy),          128'(1));
    chk("bl_grant1",      128'(grant_idx),     128'(1));
    chk("bl_grant1_addr", 128'(bus.oreq.addr), 128'(32'h0000_c000));
    serve(1, 1, "bl1");
    set_req(1, 1'b0, 8'd0, 32'h0);

    // Weighted share 3:1, both requesters continuously valid
    tick();
    cfg_weight = {4'd1, 4'd3};
    pulse_reset();
    set_req(0, 1'b1, 8'd0, 32'h0000_0100);
    set_req(1, 1'b1, 8'd0, 32'h0000_0200);
    for (int k = 0; k < 9; k++) serve(exp_wrr[k], 1, $sformatf("wrr%0d", k));

    // Zero weights behave as weight one: strict alternation
    set_req(0, 1'b0, 8'd0, 32'h0);
    set_req(1, 1'b0, 8'd0, 32'h0);
    tick();
    cfg_weight = 8'h00;
    pulse_reset();
    set_req(0, 1'b1, 8'd0, 32'h0000_0100);
    set_req(1, 1'b1, 8'd0, 32'h0000_0200);
    for (int k = 0; k < 4; k++) serve(exp_zero[k], 1, $sformatf("w0_%0d", k));

    // Watchdog with TIMEOUT=8
    set_req(1, 1'b0, 8'd0, 32'h0);
    tick();
    cfg_weight = {4'd1, 4'd1};
    pulse_reset();
    wait_busy("wd");
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("wd_clear_stall%0d", k), 128'(timeout_err), 128'(0));
      tick();
    end
    chk("wd_set",        128'(timeout_err), 128'(1));
    chk("wd_hold_busy",  128'(busy),        128'(1));
    chk("wd_hold_grant", 128'(grant_idx),   128'(0));
    bus.oresp.ready = 1'b1;
    bus.oresp.last  = 1'b1;
    tick();
    bus.oresp = '0;
    set_req(0, 1'b0, 8'd0, 32'h0);
    #1;
    chk("wd_done_busy", 128'(busy),        128'(0));
    chk("wd_sticky",    128'(timeout_err), 128'(1));

    // Asynchronous reset in the middle of a burst
    set_req(0, 1'b1, 8'd3, 32'h0000_e000);
    wait_busy("ar");
    bus.oresp.ready = 1'b1;
    bus.oresp.last  = 1'b0;
    tick();
    bus.oresp = '0;
    #1;
    chk("ar_midburst_busy", 128'(busy), 128'(1));
    reset = 1'b1;
    #1;
    chk("ar_oreq",    128'(bus.oreq),    128'(0));
    chk("ar_iresps",  128'(bus.iresps),  128'(0));
    chk("ar_busy",    128'(busy),        128'(0));
    chk("ar_timeout", 128'(timeout_err), 128'(0));
    chk("ar_grant",   128'(grant_idx),   128'(0));
    tick();
    set_req(0, 1'b1, 8'd0, 32'h0000_e000);
    set_req(1, 1'b1, 8'd0, 32'h0000_f000);
    reset = 1'b0;
    serve(0, 1, "ar_post0");
    serve(1, 1, "ar_post1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
